// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared constants, default width (from `W_COE) and stage record for pipelined_adder
`ifndef W_COE
`define W_COE 8
`endif
package pipelined_adder_pkg;
   localparam int DEF_WIDTH = `W_COE;
   localparam int DEF_STAGES = 4;
   localparam int SEG = DEF_WIDTH / DEF_STAGES;
   typedef struct packed {
      logic valid;
      logic [DEF_WIDTH-1:0] a_rem;
      logic [DEF_WIDTH-1:0] b_rem;
      logic [DEF_WIDTH-1:0] sum_lo;
      logic carry;
   } stage_t;
   function automatic int seg_bits(input int width, input int stages);
      return width / stages;
   endfunction
endpackage

// File: rtl/pipelined_adder_segment.sv
// adder_segment: combinational SEG-bit ripple adder built from full_adder_1bit cells
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_segment #(parameter int SEG = 2) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);
   logic [SEG:0] c;
   assign c[0] = ci;
   assign co = c[SEG];
   for (genvar i = 0; i < SEG; i++) begin : g_bit
      full_adder_1bit u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
   end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-segmented adder/subtractor with valid/ready flow control
// Optional signed-overflow output ovf is enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int SW = seg_bits(WIDTH, STAGES);
   typedef struct packed {
      logic valid;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] sum_lo;
      logic carry;
   } rec_t;
   logic adv;
   if (WIDTH % STAGES != 0) begin : g_chk
      $error("pipelined_adder: WIDTH must be a multiple of STAGES");
   end
   assign adv = !out_valid || out_ready;
   assign in_ready = !rst_n || adv;
   for (genvar k = 0; k < STAGES; k++) begin : stg
      rec_t src, dst, q;
      logic [SW-1:0] s;
      logic co;
      if (k == 0) begin : g_in
         // subtraction folds into addition: a + ~b + ~cin
         assign src = '{valid: in_valid, a_rem: a, b_rem: sub ? ~b : b, sum_lo: '0, carry: sub ? ~cin : cin};
      end else begin : g_link
         assign src = stg[k-1].q;
      end
      adder_segment #(.SEG(SW)) u_seg (
         .a(src.a_rem[k*SW +: SW]), .b(src.b_rem[k*SW +: SW]), .ci(src.carry), .s(s), .co(co)
      );
      always_comb begin
         dst = src;
         dst.sum_lo[k*SW +: SW] = s;
         dst.carry = co;
      end
      always_ff @(posedge clk)
         if (!rst_n) q <= '0;
         else if (adv) q <= dst;
   end
   assign out_valid = stg[STAGES-1].q.valid;
   assign sum = stg[STAGES-1].q.sum_lo;
   assign cout = stg[STAGES-1].q.carry;
`ifdef PIPE_ADDER_OVF_EN
   // carry into the MSB is recovered as a ^ b ^ s at that bit
   always_ff @(posedge clk)
      if (!rst_n) ovf <= 1'b0;
      else if (adv) ovf <= stg[STAGES-1].src.a_rem[WIDTH-1] ^ stg[STAGES-1].src.b_rem[WIDTH-1]
                           ^ stg[STAGES-1].s[SW-1] ^ stg[STAGES-1].co;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;
   localparam int W = 8;
   localparam int N = 4;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a = '0, b = '0;
   logic in_ready, out_valid, cout, ovf;
   logic [W-1:0] sum;
   typedef struct {
      logic [W-1:0] sum;
      logic cout;
      logic ovf;
      int age;
   } exp_t;
   exp_t q[$];
   int n_cmp = 0, n_bad = 0, n_out = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );
`ifndef PIPE_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // plain integer arithmetic: unsigned result, no-borrow flag and signed range check
   function automatic exp_t model(input logic [W-1:0] ta, tb, input logic tc, ts);
      exp_t e;
      int r, sr;
      if (!ts) begin
         r = int'(ta) + int'(tb) + int'(tc);
         e.cout = r > 255;
         sr = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
      end else begin
         r = int'(ta) - int'(tb) - int'(tc);
         e.cout = r >= 0;
         sr = int'($signed(ta)) - int'($signed(tb)) - int'(tc);
      end
      e.sum = r[W-1:0];
      e.ovf = sr > 127 || sr < -128;
      e.age = 1;
      return e;
   endfunction

   // each accepted beat needs N advancing cycles; the oldest beat is the one presented
   always @(negedge clk) begin
      bit ev;
      ev = q.size() > 0 && q[0].age == N;
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !rst_n || !ev || out_ready);
      if (ev) begin
         chk("sum", sum, q[0].sum);
         chk("cout", cout, q[0].cout);
`ifdef PIPE_ADDER_OVF_EN
         chk("ovf", ovf, q[0].ovf);
`endif
      end
      if (!rst_n) q.delete();
      else if (!ev || out_ready) begin
         if (ev) begin
            void'(q.pop_front());
            n_out++;
         end
         foreach (q[i]) q[i].age++;
         if (in_valid) q.push_back(model(a, b, cin, sub));
      end
   end

   task automatic drive(input logic [W-1:0] ta, tb, input logic tc, ts);
      bit acc = 1'b0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("accept", acc, 1);
   endtask

   task automatic directed(input string nm, input logic [W-1:0] ta, tb, input logic tc, ts,
                           input logic [W-1:0] es, input logic ec, eo);
      drive(ta, tb, tc, ts);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk({nm, " latency"}, out_valid, i == N - 1);
      end
      chk({nm, " sum"}, sum, es);
      chk({nm, " cout"}, cout, ec);
`ifdef PIPE_ADDER_OVF_EN
      chk({nm, " ovf"}, ovf, eo);
`else
      chk({nm, " ovf model"}, model(ta, tb, tc, ts).ovf, eo);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset sum", sum, 0);
      chk("reset cout", cout, 0);
      rst_n = 1'b1;
      directed("add 0F+01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      directed("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      directed("sub 05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      directed("sub 07-05-1", 8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
      // six back-to-back beats with a three-cycle consumer stall in the middle
      base = n_out;
      fork
         for (int i = 0; i < 6; i++) drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
         begin
            repeat (5) @(posedge clk);
            #2;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      repeat (N + 2) @(posedge clk);
      #1;
      chk("stream count", n_out - base, 6);
      // reset with beats in flight discards them
      for (int i = 0; i < 3; i++) drive(W'($urandom), W'($urandom), 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid reset out_valid", out_valid, 0);
      chk("mid reset sum", sum, 0);
      directed("post-reset", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
      directed("ovf 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      directed("ovf 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      directed("ovf 10+20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         in_valid = 1'($urandom);
         out_ready = $urandom_range(3) != 0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (N + 2) @(posedge clk);
      #1;
      chk("drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
